// File: rtl/mem_port_arbiter.sv
// Two-port round-robin arbiter in front of a single-port memory with fixed read latency.
// One transaction in flight; each port uses a held-request / one-cycle-ack handshake.
module mem_port_arbiter #(
   parameter int n   = 16,
   parameter int LAT = 2,
   parameter int CW  = 4
) (
   input  logic         clk,
   input  logic         reset,
   input  logic         req0,
   input  logic         we0,
   input  logic [n-1:0] addr0,
   input  logic [n-1:0] wdata0,
   output logic         ack0,
   output logic [n-1:0] rdata0,
   input  logic         req1,
   input  logic         we1,
   input  logic [n-1:0] addr1,
   input  logic [n-1:0] wdata1,
   output logic         ack1,
   output logic [n-1:0] rdata1,
   output logic         mem_en,
   output logic         mem_we,
   output logic [n-1:0] mem_addr,
   output logic [n-1:0] mem_wdata,
   input  logic [n-1:0] mem_rdata,
   output logic         busy,
   output logic         gnt
);

   typedef enum logic [1:0] {S_IDLE, S_ISSUE, S_WAIT, S_RESP} state_t;

   state_t        state_q, state_d;
   logic [CW-1:0] cnt_q, cnt_d;
   logic          last_q, last_d;
   logic          gnt_q, gnt_d;
   logic          we_q, we_d;
   logic [n-1:0]  addr_q, addr_d;
   logic [n-1:0]  wdata_q, wdata_d;
   logic          win;
   logic          resp;

   always_ff @(posedge clk or negedge reset) begin
      if (!reset) begin
         state_q <= S_IDLE;
         cnt_q   <= '0;
         last_q  <= 1'b1;
         gnt_q   <= 1'b0;
         we_q    <= 1'b0;
         addr_q  <= '0;
         wdata_q <= '0;
      end else begin
         state_q <= state_d;
         cnt_q   <= cnt_d;
         last_q  <= last_d;
         gnt_q   <= gnt_d;
         we_q    <= we_d;
         addr_q  <= addr_d;
         wdata_q <= wdata_d;
      end
   end

   always_comb begin
      state_d = state_q;
      cnt_d   = cnt_q;
      last_d  = last_q;
      gnt_d   = gnt_q;
      we_d    = we_q;
      addr_d  = addr_q;
      wdata_d = wdata_q;
      win     = 1'b0;
      case (state_q)
         S_IDLE: begin
            if (req0 || req1) begin
               // A lone requester wins outright; on contention the port that did not go last wins.
               win     = (req0 && req1) ? ~last_q : req1;
               gnt_d   = win;
               we_d    = win ? we1    : we0;
               addr_d  = win ? addr1  : addr0;
               wdata_d = win ? wdata1 : wdata0;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            cnt_d   = CW'(LAT - 1);
            state_d = (LAT == 1) ? S_RESP : S_WAIT;
         end
         S_WAIT: begin
            cnt_d = cnt_q - 1'b1;
            if (cnt_q == CW'(1)) begin
               state_d = S_RESP;
            end
         end
         S_RESP: begin
            last_d  = gnt_q;
            state_d = S_IDLE;
         end
         default: state_d = S_IDLE;
      endcase
   end

   always_comb begin
      resp      = (state_q == S_RESP);
      mem_en    = (state_q == S_ISSUE);
      mem_we    = (state_q == S_ISSUE) && we_q;
      mem_addr  = addr_q;
      mem_wdata = wdata_q;
      busy      = (state_q != S_IDLE);
      gnt       = gnt_q;
      ack0      = resp && !gnt_q;
      ack1      = resp && gnt_q;
      // Write completions return zero data; read data is only forwarded during the ack cycle.
      rdata0    = (ack0 && !we_q) ? mem_rdata : '0;
      rdata1    = (ack1 && !we_q) ? mem_rdata : '0;
   end

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Bench for mem_port_arbiter: a LAT=2 instance and a LAT=1 instance, each backed by a
// small behavioural memory, with a queue of expected acks checked as they appear.
module tb_mem_port_arbiter;
   localparam int N     = 16;
   localparam int LAT_A = 2;

   logic         clk = 1'b0;
   logic         reset = 1'b0;

   logic         req0 = 1'b0, we0 = 1'b0, req1 = 1'b0, we1 = 1'b0;
   logic [N-1:0] addr0 = '0, wdata0 = '0, addr1 = '0, wdata1 = '0;
   logic         ack0, ack1, mem_en, mem_we, busy, gnt;
   logic [N-1:0] rdata0, rdata1, mem_addr, mem_wdata, mem_rdata;

   logic         u1_req0 = 1'b0, u1_we0 = 1'b0, u1_req1 = 1'b0, u1_we1 = 1'b0;
   logic [N-1:0] u1_addr0 = '0, u1_wdata0 = '0, u1_addr1 = '0, u1_wdata1 = '0;
   logic         u1_ack0, u1_ack1, u1_mem_en, u1_mem_we, u1_busy, u1_gnt;
   logic [N-1:0] u1_rdata0, u1_rdata1, u1_mem_addr, u1_mem_wdata, u1_mem_rdata;

   int total = 0;
   int bad   = 0;
   int cyc   = 0;
   logic [16:0] exp_q[$];
   logic [16:0] exp1_q[$];

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   mem_port_arbiter #(.n(N), .LAT(LAT_A), .CW(4)) dut (
      .clk(clk), .reset(reset),
      .req0(req0), .we0(we0), .addr0(addr0), .wdata0(wdata0), .ack0(ack0), .rdata0(rdata0),
      .req1(req1), .we1(we1), .addr1(addr1), .wdata1(wdata1), .ack1(ack1), .rdata1(rdata1),
      .mem_en(mem_en), .mem_we(mem_we), .mem_addr(mem_addr), .mem_wdata(mem_wdata),
      .mem_rdata(mem_rdata), .busy(busy), .gnt(gnt)
   );

   mem_port_arbiter #(.n(N), .LAT(1), .CW(4)) dut1 (
      .clk(clk), .reset(reset),
      .req0(u1_req0), .we0(u1_we0), .addr0(u1_addr0), .wdata0(u1_wdata0), .ack0(u1_ack0), .rdata0(u1_rdata0),
      .req1(u1_req1), .we1(u1_we1), .addr1(u1_addr1), .wdata1(u1_wdata1), .ack1(u1_ack1), .rdata1(u1_rdata1),
      .mem_en(u1_mem_en), .mem_we(u1_mem_we), .mem_addr(u1_mem_addr), .mem_wdata(u1_mem_wdata),
      .mem_rdata(u1_mem_rdata), .busy(u1_busy), .gnt(u1_gnt)
   );

   // Unwritten locations read back a fixed pattern; a few addresses carry named values.
   function automatic logic [15:0] dflt(input logic [15:0] a);
      case (a)
         16'h0010: dflt = 16'hBEEF;
         16'h0FFF: dflt = 16'h7777;
         default:  dflt = {a[7:0] ^ 8'h5A, a[7:0]};
      endcase
   endfunction

   // Memory behind the LAT=2 instance: data is presented exactly LAT cycles after mem_en.
   bit [15:0] mdl_a [256];
   bit        mdl_a_v [256];
   bit [15:0] pipe_a [LAT_A];
   bit        pv_a [LAT_A];
   always @(posedge clk) begin
      if (mem_en && mem_we) begin
         mdl_a[mem_addr[7:0]]   <= mem_wdata;
         mdl_a_v[mem_addr[7:0]] <= 1'b1;
      end
      pv_a[0]   <= mem_en && !mem_we;
      pipe_a[0] <= mdl_a_v[mem_addr[7:0]] ? mdl_a[mem_addr[7:0]] : dflt(mem_addr);
      for (int i = 1; i < LAT_A; i++) begin
         pv_a[i]   <= pv_a[i-1];
         pipe_a[i] <= pipe_a[i-1];
      end
   end
   assign mem_rdata = pv_a[LAT_A-1] ? pipe_a[LAT_A-1] : 16'hDEAD;

   bit [15:0] mdl_b [256];
   bit        mdl_b_v [256];
   bit [15:0] pipe_b;
   bit        pv_b;
   always @(posedge clk) begin
      if (u1_mem_en && u1_mem_we) begin
         mdl_b[u1_mem_addr[7:0]]   <= u1_mem_wdata;
         mdl_b_v[u1_mem_addr[7:0]] <= 1'b1;
      end
      pv_b   <= u1_mem_en && !u1_mem_we;
      pipe_b <= mdl_b_v[u1_mem_addr[7:0]] ? mdl_b[u1_mem_addr[7:0]] : dflt(u1_mem_addr);
   end
   assign u1_mem_rdata = pv_b ? pipe_b : 16'hDEAD;

   // Scoreboard: every ack pops the oldest expected {port, data}.
   always @(negedge clk) begin
      logic [16:0] got, want;
      if (ack0 || ack1) begin
         got = {ack1, ack1 ? rdata1 : rdata0};
         $display("txn A port=%0d data=%h cyc=%0d", got[16], got[15:0], cyc);
         total++;
         if (ack0 && ack1) begin
            bad++;
            $display("FAIL A_dual_ack ack0=%b ack1=%b required one", ack0, ack1);
         end
         total++;
         if (exp_q.size() == 0) begin
            bad++;
            $display("FAIL A_unexpected_ack got=%h required=none", got);
         end else begin
            want = exp_q.pop_front();
            if (got !== want) begin
               bad++;
               $display("FAIL A_sb got=%h required=%h", got, want);
            end
         end
      end
      if (u1_ack0 || u1_ack1) begin
         got = {u1_ack1, u1_ack1 ? u1_rdata1 : u1_rdata0};
         $display("txn B port=%0d data=%h cyc=%0d", got[16], got[15:0], cyc);
         total++;
         if (exp1_q.size() == 0) begin
            bad++;
            $display("FAIL B_unexpected_ack got=%h required=none", got);
         end else begin
            want = exp1_q.pop_front();
            if (got !== want) begin
               bad++;
               $display("FAIL B_sb got=%h required=%h", got, want);
            end
         end
      end
   end

   task automatic test_reset();
      reset = 1'b0;
      repeat (2) @(negedge clk);
      total++;
      if ({ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy, gnt} !== '0) begin
         bad++;
         $display("FAIL reset_A got=%h required=0",
                  {ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy, gnt});
      end
      total++;
      if ({u1_ack0, u1_ack1, u1_rdata0, u1_rdata1, u1_mem_en, u1_mem_we, u1_mem_addr,
           u1_mem_wdata, u1_busy, u1_gnt} !== '0) begin
         bad++;
         $display("FAIL reset_B busy=%b mem_en=%b required 0", u1_busy, u1_mem_en);
      end
      reset = 1'b1;
   endtask

   task automatic test_read();
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010; wdata0 = 16'h5555;
      exp_q.push_back({1'b0, 16'hBEEF});
      @(negedge clk);
      total++;
      if ({mem_en, mem_we, mem_addr, busy, gnt} !== {1'b1, 1'b0, 16'h0010, 1'b1, 1'b0}) begin
         bad++;
         $display("FAIL read_issue en=%b we=%b addr=%h busy=%b gnt=%b required 1 0 0010 1 0",
                  mem_en, mem_we, mem_addr, busy, gnt);
      end
      @(negedge clk);
      total++;
      if ({mem_en, ack0, busy} !== 3'b001) begin
         bad++;
         $display("FAIL read_wait en=%b ack0=%b busy=%b required 0 0 1", mem_en, ack0, busy);
      end
      @(negedge clk);
      total++;
      if ({ack0, rdata0, ack1} !== {1'b1, 16'hBEEF, 1'b0}) begin
         bad++;
         $display("FAIL read_ack ack0=%b rdata0=%h ack1=%b required 1 beef 0", ack0, rdata0, ack1);
      end
      req0 = 1'b0;
      @(negedge clk);
      total++;
      if ({busy, ack0, rdata0} !== '0) begin
         bad++;
         $display("FAIL read_idle busy=%b ack0=%b rdata0=%h required 0", busy, ack0, rdata0);
      end
   endtask

   task automatic test_write();
      @(negedge clk);
      req1 = 1'b1; we1 = 1'b1; addr1 = 16'h0020; wdata1 = 16'h1234;
      exp_q.push_back({1'b1, 16'h0000});
      @(negedge clk);
      total++;
      if ({mem_en, mem_we, mem_addr, mem_wdata, gnt} !== {1'b1, 1'b1, 16'h0020, 16'h1234, 1'b1}) begin
         bad++;
         $display("FAIL write_issue en=%b we=%b addr=%h wdata=%h gnt=%b required 1 1 0020 1234 1",
                  mem_en, mem_we, mem_addr, mem_wdata, gnt);
      end
      @(negedge clk);
      total++;
      if ({mem_en, ack1} !== 2'b00) begin
         bad++;
         $display("FAIL write_wait en=%b ack1=%b required 0 0", mem_en, ack1);
      end
      @(negedge clk);
      total++;
      if ({ack1, rdata1, ack0} !== {1'b1, 16'h0000, 1'b0}) begin
         bad++;
         $display("FAIL write_ack ack1=%b rdata1=%h ack0=%b required 1 0000 0", ack1, rdata1, ack0);
      end
      req1 = 1'b0; we1 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_back_to_back();
      int start, acks, want_cyc;
      reset = 1'b0;
      @(negedge clk);
      reset = 1'b1;
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0020;
      req1 = 1'b1; we1 = 1'b0; addr1 = 16'h0030;
      for (int k = 0; k < 2; k++) begin
         exp_q.push_back({1'b0, 16'h1234});
         exp_q.push_back({1'b1, 16'h6A30});
      end
      start = cyc;
      acks  = 0;
      for (int k = 0; k < 40 && acks < 4; k++) begin
         @(negedge clk);
         if (ack0 || ack1) begin
            total++;
            if (ack1 !== acks[0]) begin
               bad++;
               $display("FAIL b2b_order txn=%0d port=%b required=%0d", acks, ack1, acks % 2);
            end
            want_cyc = start + LAT_A + 1 + acks * (LAT_A + 2);
            total++;
            if (cyc != want_cyc) begin
               bad++;
               $display("FAIL b2b_timing txn=%0d cyc=%0d required=%0d", acks, cyc, want_cyc);
            end
            acks++;
            if (acks == 4) begin
               req0 = 1'b0; req1 = 1'b0;
            end
         end
      end
      total++;
      if (acks != 4) begin
         bad++;
         $display("FAIL b2b_timeout acks=%0d required=4", acks);
         req0 = 1'b0; req1 = 1'b0;
      end
      @(negedge clk);
   endtask

   task automatic test_addr_change();
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0010;
      exp_q.push_back({1'b0, 16'hBEEF});
      @(negedge clk);
      @(negedge clk);
      addr0 = 16'h0FFF; wdata0 = 16'hFFFF; we0 = 1'b1;
      @(negedge clk);
      total++;
      if ({mem_addr, ack0, rdata0} !== {16'h0010, 1'b1, 16'hBEEF}) begin
         bad++;
         $display("FAIL addr_hold addr=%h ack0=%b rdata0=%h required 0010 1 beef", mem_addr, ack0, rdata0);
      end
      req0 = 1'b0; we0 = 1'b0; addr0 = 16'h0000;
      @(negedge clk);
      total++;
      if (mem_addr !== 16'h0010) begin
         bad++;
         $display("FAIL addr_after addr=%h required=0010", mem_addr);
      end
   endtask

   task automatic test_reset_mid();
      @(negedge clk);
      req0 = 1'b1; we0 = 1'b0; addr0 = 16'h0050;
      @(negedge clk);
      @(negedge clk);
      reset = 1'b0;
      #1;
      total++;
      if ({ack0, ack1, rdata0, rdata1, mem_en, mem_we, mem_addr, mem_wdata, busy, gnt} !== '0) begin
         bad++;
         $display("FAIL reset_mid busy=%b addr=%h ack0=%b required all 0", busy, mem_addr, ack0);
      end
      @(negedge clk);
      total++;
      if ({ack0, busy} !== 2'b00) begin
         bad++;
         $display("FAIL reset_hold ack0=%b busy=%b required 0 0", ack0, busy);
      end
      exp_q.push_back({1'b0, 16'h0A50});
      reset = 1'b1;
      @(negedge clk);
      total++;
      if ({mem_en, mem_addr} !== {1'b1, 16'h0050}) begin
         bad++;
         $display("FAIL reissue en=%b addr=%h required 1 0050", mem_en, mem_addr);
      end
      @(negedge clk);
      @(negedge clk);
      total++;
      if ({ack0, rdata0} !== {1'b1, 16'h0A50}) begin
         bad++;
         $display("FAIL reissue_ack ack0=%b rdata0=%h required 1 0a50", ack0, rdata0);
      end
      req0 = 1'b0;
      @(negedge clk);
   endtask

   task automatic test_lat1();
      logic [15:0] a_t [3] = '{16'h0060, 16'h0061, 16'h0061};
      logic        w_t [3] = '{1'b0, 1'b1, 1'b0};
      logic [15:0] d_t [3] = '{16'h0000, 16'hABCD, 16'h0000};
      logic [15:0] r_t [3] = '{16'h3A60, 16'h0000, 16'hABCD};
      for (int k = 0; k < 3; k++) begin
         @(negedge clk);
         u1_req1 = 1'b1; u1_we1 = w_t[k]; u1_addr1 = a_t[k]; u1_wdata1 = d_t[k];
         exp1_q.push_back({1'b1, r_t[k]});
         @(negedge clk);
         total++;
         if ({u1_mem_en, u1_mem_we, u1_ack1} !== {1'b1, w_t[k], 1'b0}) begin
            bad++;
            $display("FAIL lat1_issue txn=%0d en=%b we=%b ack1=%b", k, u1_mem_en, u1_mem_we, u1_ack1);
         end
         @(negedge clk);
         total++;
         if ({u1_ack1, u1_rdata1, u1_ack0, u1_rdata0} !== {1'b1, r_t[k], 1'b0, 16'h0000}) begin
            bad++;
            $display("FAIL lat1_ack txn=%0d ack1=%b rdata1=%h ack0=%b rdata0=%h required 1 %h 0 0000",
                     k, u1_ack1, u1_rdata1, u1_ack0, u1_rdata0, r_t[k]);
         end
         u1_req1 = 1'b0; u1_we1 = 1'b0;
         @(negedge clk);
         total++;
         if ({u1_busy, u1_ack1} !== 2'b00) begin
            bad++;
            $display("FAIL lat1_idle txn=%0d busy=%b ack1=%b required 0 0", k, u1_busy, u1_ack1);
         end
      end
   endtask

   initial begin
      test_reset();
      test_read();
      test_write();
      test_back_to_back();
      test_addr_change();
      test_reset_mid();
      test_lat1();
      repeat (2) @(negedge clk);
      total++;
      if (exp_q.size() != 0 || exp1_q.size() != 0) begin
         bad++;
         $display("FAIL sb_leftover A=%0d B=%0d required 0 0", exp_q.size(), exp1_q.size());
      end
      $display("test done: total=%0d bad=%0d", total, bad);
      $finish;
   end

endmodule
